// File: rtl/match_log_pkg.sv
// Shared defaults, occupancy-state type and saturating increment for the match logger.
package match_log_pkg;

    localparam int unsigned IDX_W_DEF = 16;
    localparam int unsigned DEPTH_DEF = 4;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_PART  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Increment, holding at the all-ones value of a width-bit counter (width <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hffff_ffff : ((32'd1 << width) - 32'd1);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/seq_match_logger_if.sv
// Host-side bundle of the match logger. MATCH_LOG_DROP_CNT_EN adds the drop_cnt summary output.
interface seq_match_logger_if #(
    parameter int unsigned IDX_W = match_log_pkg::IDX_W_DEF,
    parameter int unsigned CNT_W = match_log_pkg::CNT_W_DEF
);
    logic             clr;
    logic             det;
    logic             ev_valid;
    logic             ev_ready;
    logic [IDX_W-1:0] ev_idx;
    logic [CNT_W-1:0] match_cnt;
    logic             fifo_full;
    logic             drop;
`ifdef MATCH_LOG_DROP_CNT_EN
    logic [CNT_W-1:0] drop_cnt;

    modport master (
        input  clr, det, ev_ready,
        output ev_valid, ev_idx, match_cnt, fifo_full, drop, drop_cnt
    );
    modport slave (
        output clr, det, ev_ready,
        input  ev_valid, ev_idx, match_cnt, fifo_full, drop, drop_cnt
    );
`else
    modport master (
        input  clr, det, ev_ready,
        output ev_valid, ev_idx, match_cnt, fifo_full, drop
    );
    modport slave (
        output clr, det, ev_ready,
        input  ev_valid, ev_idx, match_cnt, fifo_full, drop
    );
`endif
endinterface

// File: rtl/match_log_fifo.sv
// First-word-fall-through event FIFO; occupancy tracked by an EMPTY/PART/FULL state machine.
module match_log_fifo
    import match_log_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [IDX_W-1:0] din_i,
    output logic [IDX_W-1:0] dout_o,
    output logic             valid_o,
    output logic             full_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [IDX_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    occ_e             state_q, state_d;
    logic             pop_ok, push_ok;

    assign pop_ok  = pop_i && (state_q != OCC_EMPTY);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push_i && ((state_q != OCC_FULL) || pop_ok);

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr_i) begin
            state_d  = OCC_EMPTY;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PW'(push_ok);
            rd_ptr_d = rd_ptr_q + PW'(pop_ok);
            cnt_d    = cnt_q + CW'(push_ok) - CW'(pop_ok);
            unique case (state_q)
                OCC_EMPTY: if (push_ok) state_d = OCC_PART;
                OCC_PART: begin
                    if (push_ok && !pop_ok && (cnt_q == CW'(DEPTH - 1))) state_d = OCC_FULL;
                    if (pop_ok && !push_ok && (cnt_q == CW'(1)))         state_d = OCC_EMPTY;
                end
                OCC_FULL:  if (pop_ok && !push_ok) state_d = OCC_PART;
                default:   state_d = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= OCC_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clr_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign valid_o = (state_q != OCC_EMPTY);
    assign full_o  = (state_q == OCC_FULL);
    assign dout_o  = valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/seq_match_logger.sv
// Timestamps detector pulses with a free-running bit index and queues them for the host.
// MATCH_LOG_DROP_CNT_EN adds a saturating count of events lost to a full queue.
module seq_match_logger
    import match_log_pkg::*;
#(
    parameter int unsigned IDX_W = IDX_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input logic                clk,
    input logic                rst_n,
    seq_match_logger_if.master bus
);
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic             drop_q, drop_d;
    logic             fifo_valid, fifo_full;
    logic [IDX_W-1:0] fifo_dout;

    match_log_fifo #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (bus.clr),
        .push_i  (bus.det),
        .pop_i   (bus.ev_ready),
        .din_i   (idx_q),
        .dout_o  (fifo_dout),
        .valid_o (fifo_valid),
        .full_o  (fifo_full)
    );

    always_comb begin
        idx_d       = idx_q + IDX_W'(1);
        match_cnt_d = match_cnt_q;
        drop_d      = 1'b0;
        if (bus.clr) begin
            idx_d       = '0;
            match_cnt_d = '0;
        end else if (bus.det) begin
            match_cnt_d = CNT_W'(sat_inc(32'(match_cnt_q), CNT_W));
            drop_d      = fifo_full && !(fifo_valid && bus.ev_ready);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            match_cnt_q <= '0;
            drop_q      <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            match_cnt_q <= match_cnt_d;
            drop_q      <= drop_d;
        end
    end

`ifdef MATCH_LOG_DROP_CNT_EN
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (bus.clr)     drop_cnt_d = '0;
        else if (drop_d) drop_cnt_d = CNT_W'(sat_inc(32'(drop_cnt_q), CNT_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign bus.drop_cnt = drop_cnt_q;
`endif

    assign bus.ev_valid  = fifo_valid;
    assign bus.ev_idx    = fifo_dout;
    assign bus.match_cnt = match_cnt_q;
    assign bus.fifo_full = fifo_full;
    assign bus.drop      = drop_q;

endmodule

// File: tb/tb_seq_match_logger.sv
// Scoreboard bench for seq_match_logger: directed scenarios plus a random 10110 bit stream.
module tb_seq_match_logger;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 8;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_match_logger_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

    seq_match_logger #(
        .IDX_W (IDX_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model: queue of expected event indices plus summary counters.
    int exp_q[$];
    int mdl_idx, mdl_cnt, mdl_match, mdl_drop_cnt;
    bit mdl_drop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        mdl_idx      = 0;
        mdl_cnt      = 0;
        mdl_match    = 0;
        mdl_drop_cnt = 0;
        mdl_drop     = 1'b0;
    endtask

    task automatic model_update(input bit d, input bit r, input bit c);
        bit pop, acc;
        if (c) begin
            model_reset();
            return;
        end
        pop = (mdl_cnt > 0) && r;
        acc = d && ((mdl_cnt < DEPTH) || pop);
        if (acc) exp_q.push_back(mdl_idx);
        mdl_drop = d && !acc;
        if (mdl_drop && mdl_drop_cnt < CMAX) mdl_drop_cnt++;
        if (d && mdl_match < CMAX) mdl_match++;
        mdl_cnt = mdl_cnt + int'(acc) - int'(pop);
        mdl_idx = (mdl_idx + 1) % (1 << IDX_W);
    endtask

    task automatic check_outputs();
        chk("ev_valid", bus.ev_valid, mdl_cnt > 0);
        chk("fifo_full", bus.fifo_full, mdl_cnt == DEPTH);
        chk("match_cnt", bus.match_cnt, mdl_match);
        chk("drop", bus.drop, mdl_drop);
`ifdef MATCH_LOG_DROP_CNT_EN
        chk("drop_cnt", bus.drop_cnt, mdl_drop_cnt);
`endif
    endtask

    // Called at posedge+1; leaves at the following posedge+1.
    task automatic step(input bit d, input bit r, input bit c);
        bus.det      = d;
        bus.ev_ready = r;
        bus.clr      = c;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update(d, r, c);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("rst_ev_valid", bus.ev_valid, 1'b0);
        chk("rst_ev_idx", bus.ev_idx, 0);
        chk("rst_match_cnt", bus.match_cnt, 0);
        chk("rst_fifo_full", bus.fifo_full, 1'b0);
        chk("rst_drop", bus.drop, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
    endtask

    // Monitor: every accepted head must match the oldest expected index.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.ev_valid === 1'b1 && bus.ev_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL ev_idx_unexpected: got %0d expected none at %0t",
                         bus.ev_idx, $time);
            end else begin
                chk("ev_idx", bus.ev_idx, exp_q.pop_front());
            end
        end
    end

    logic [4:0] hist;
    bit         rd, rb;

    initial begin
        bus.det      = 1'b0;
        bus.ev_ready = 1'b0;
        bus.clr      = 1'b0;
        do_reset();

        // Reset mid-run with two events queued; index restarts at 0.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        drain(3);

        // Single event at index 5.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        #1;
        chk("t2_ev_valid", bus.ev_valid, 1'b1);
        chk("t2_ev_idx", bus.ev_idx, 5);
        chk("t2_match_cnt", bus.match_cnt, 1);
        drain(2);

        // Overflow: detections at 1,3,5,7,9 with the consumer stalled.
        do_reset();
        for (int i = 0; i < 10; i++) step(i % 2 == 1, 1'b0, 1'b0);
        #1;
        chk("t3_drop", bus.drop, 1'b1);
        chk("t3_full", bus.fifo_full, 1'b1);
        chk("t3_match_cnt", bus.match_cnt, 5);
`ifdef MATCH_LOG_DROP_CNT_EN
        chk("t3_drop_cnt", bus.drop_cnt, 1);
`endif
        drain(6);

        // Full with simultaneous pop and push.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        #1;
        chk("t4_full", bus.fifo_full, 1'b1);
        chk("t4_drop", bus.drop, 1'b0);
        chk("t4_head", bus.ev_idx, 1);
        drain(6);

        // Index wrap at 4 bits, then match counter saturation.
        do_reset();
        for (int i = 0; i < 18; i++) step(i == 15 || i == 17, 1'b0, 1'b0);
        drain(3);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b0);
        #1;
        chk("t5_match_sat", bus.match_cnt, CMAX);
        drain(6);

        // Clear with a coincident detection and three queued events.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        #1;
        chk("t6_ev_valid", bus.ev_valid, 1'b0);
        chk("t6_match_cnt", bus.match_cnt, 0);
        step(1'b1, 1'b0, 1'b0);
        drain(2);

        // Random bit stream through a behavioural overlapping 10110 Moore detector.
        do_reset();
        hist = 5'b0;
        for (int i = 0; i < 4000; i++) begin
            rd = (hist == 5'b10110);
            hist = {hist[3:0], 1'($urandom)};
            rb = (i < 2000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            step(rd || ($urandom_range(0, 9) == 0), rb, $urandom_range(0, 299) == 0);
        end
        drain(8);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
